// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: 10-bit command/data SPI master; SPI_MASTER_AUTO_READ_EN adds an automatic read-data frame after cmd 10
module spi_master_ctrl #(
   parameter int TAIL_CYCLES = 2,
   parameter int TURN_CYCLES = 2,
   parameter int GAP_CYCLES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] cmd,
   input  logic [7:0] data_in,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       SS_n,
   output logic       MOSI,
   input  logic       MISO
);
   localparam int M1 = TAIL_CYCLES > 10 ? TAIL_CYCLES : 10;
   localparam int M2 = TURN_CYCLES > M1 ? TURN_CYCLES : M1;
   localparam int MC = GAP_CYCLES > M2 ? GAP_CYCLES : M2;
   localparam int CW = $clog2(MC);
`ifdef SPI_MASTER_AUTO_READ_EN
   localparam logic AUTO_EN = 1'b1;
`else
   localparam logic AUTO_EN = 1'b0;
`endif
   typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TAIL, TURN, RECV, GAP} state_t;
   state_t state, state_d;
   logic [CW-1:0] cnt, cnt_d;
   logic [9:0] frame, frame_d;
   logic rd, rd_d, auto_rd, auto_rd_d, fin;
   logic [6:0] rx_sh;
   // state register; reset discards any partial frame
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         frame   <= '0;
         rd      <= 1'b0;
         auto_rd <= 1'b0;
      end else begin
         state   <= state_d;
         cnt     <= cnt_d;
         frame   <= frame_d;
         rd      <= rd_d;
         auto_rd <= auto_rd_d;
      end
   // next state, frame shifting and phase counters; fin marks entry into the final GAP
   always_comb begin
      state_d   = state;
      cnt_d     = cnt - 1'b1;
      frame_d   = frame;
      rd_d      = rd;
      auto_rd_d = auto_rd;
      case (state)
         IDLE: begin
            cnt_d = '0;
            if (start) begin
               state_d   = LEAD;
               frame_d   = {cmd, &cmd ? 8'h00 : data_in};
               rd_d      = &cmd;
               auto_rd_d = AUTO_EN && cmd == 2'b10;
            end
         end
         LEAD: begin
            state_d = SHIFT;
            cnt_d   = CW'(9);
         end
         SHIFT: begin
            frame_d = frame << 1;
            if (cnt == '0) begin
               state_d = rd ? TURN : TAIL;
               cnt_d   = rd ? CW'(TURN_CYCLES - 1) : CW'(TAIL_CYCLES - 1);
            end
         end
         TAIL: if (cnt == '0) begin
            state_d = GAP;
            cnt_d   = CW'(GAP_CYCLES - 1);
         end
         TURN: if (cnt == '0) begin
            state_d = RECV;
            cnt_d   = CW'(7);
         end
         RECV: if (cnt == '0) begin
            state_d = GAP;
            cnt_d   = CW'(GAP_CYCLES - 1);
         end
         GAP: if (cnt == '0) begin
            state_d   = auto_rd ? LEAD : IDLE;
            frame_d   = auto_rd ? 10'h300 : frame;
            rd_d      = auto_rd | rd;
            auto_rd_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      fin = state_d == GAP && state != GAP && !auto_rd;
   end
   // registered outputs derived from the upcoming state so they align with it
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         SS_n     <= 1'b1;
         MOSI     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rx_valid <= 1'b0;
         rx_data  <= 8'h00;
         rx_sh    <= '0;
      end else begin
         SS_n     <= state_d == IDLE || state_d == GAP;
         MOSI     <= (state_d == LEAD || state_d == SHIFT) && frame_d[9];
         busy     <= state_d != IDLE;
         done     <= fin;
         rx_valid <= fin && rd;
         rx_sh    <= state == RECV ? {rx_sh[5:0], MISO} : rx_sh;
         rx_data  <= fin && rd ? {rx_sh, MISO} : rx_data;
      end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: scoreboard bench with a behavioural SPI slave/RAM for spi_master_ctrl (honours SPI_MASTER_AUTO_READ_EN)
module tb_spi_master_ctrl;
   logic clk, rst, start, busy, done, rx_valid, SS_n, MOSI, MISO;
   logic [1:0] cmd;
   logic [7:0] data_in, rx_data;
   int tests = 0, fails = 0;

   typedef struct {
      logic [10:0] mosi;
      int ss;
      int wins;
      logic rxv;
      logic [7:0] rx;
   } exp_t;
   exp_t q[$];
   int bq[$];

`ifdef SPI_MASTER_AUTO_READ_EN
   localparam logic [7:0]  RB  = 8'h5A;
   localparam logic [10:0] MWD = 11'h15A;
`else
   localparam logic [7:0]  RB  = 8'h96;
   localparam logic [10:0] MWD = 11'h196;
`endif

   spi_master_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .cmd(cmd), .data_in(data_in),
      .busy(busy), .done(done), .rx_data(rx_data), .rx_valid(rx_valid),
      .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic void expect_req(logic [10:0] m, int ss, int wins, int bl, logic v, logic [7:0] rx);
      exp_t e;
      e.mosi = m;
      e.ss   = ss;
      e.wins = wins;
      e.rxv  = v;
      e.rx   = rx;
      q.push_back(e);
      bq.push_back(bl);
   endfunction

   task automatic issue(input logic [1:0] c, input logic [7:0] d);
      @(negedge clk);
      start = 1'b1;
      cmd = c;
      data_in = d;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 200);
      chk("idle timeout", busy, 0);
   endtask

   // slave model: 10-bit frame after the lead cycle, reply bits on cycles 13..20 of a read-data window
   initial begin
      logic [7:0] mem [256];
      logic [7:0] waddr, raddr, rbyte;
      logic [9:0] sh;
      int sc;
      logic rdm;
      sc = 0; rdm = 1'b0; sh = '0; waddr = '0; raddr = '0; rbyte = '0; MISO = 1'b0;
      forever begin
         @(negedge clk);
         if (!SS_n) begin
            if (sc >= 1 && sc <= 10) sh = {sh[8:0], MOSI};
            if (sc == 10)
               case (sh[9:8])
                  2'b00: waddr = sh[7:0];
                  2'b01: mem[waddr] = sh[7:0];
                  2'b10: raddr = sh[7:0];
                  default: begin
                     rdm = 1'b1;
                     rbyte = mem[raddr];
                  end
               endcase
            MISO = (rdm && sc >= 13 && sc <= 20) ? rbyte[20-sc] : 1'b0;
            sc++;
         end else begin
            sc = 0;
            rdm = 1'b0;
            MISO = 1'b0;
         end
      end
   end

   // monitor: captures each SS_n window and busy run, checks against the scoreboard on done / busy fall
   initial begin
      logic [10:0] cap;
      int wc, wins, bc;
      logic bprev, ss_prev;
      exp_t e;
      int bl;
      cap = '0; wc = 0; wins = 0; bc = 0; bprev = 1'b0; ss_prev = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            wc = 0; wins = 0; bc = 0; bprev = 1'b0; ss_prev = 1'b1;
         end else begin
            if (!SS_n) begin
               if (ss_prev) begin
                  wins++;
                  wc = 0;
               end
               if (wc <= 10) cap[10-wc] = MOSI;
               wc++;
            end
            ss_prev = SS_n;
            if (busy) bc++;
            else if (bprev) begin
               if (bq.size() == 0) chk("spurious busy", bc, 0);
               else begin
                  bl = bq.pop_front();
                  chk("busy len", bc, bl);
               end
               bc = 0;
            end
            bprev = busy;
            if (done) begin
               if (q.size() == 0) chk("spurious done", done, 0);
               else begin
                  e = q.pop_front();
                  chk("mosi frame", cap, e.mosi);
                  chk("ss low len", wc, e.ss);
                  chk("ss windows", wins, e.wins);
                  chk("rx_valid", rx_valid, e.rxv);
                  chk("rx_data", rx_data, e.rx);
               end
               wins = 0;
            end else if (rx_valid) chk("rx_valid without done", rx_valid, 0);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; start = 1'b0; cmd = 2'b00; data_in = 8'h00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reset SS_n", SS_n, 1);
         chk("reset MOSI", MOSI, 0);
         chk("reset busy", busy, 0);
         chk("reset rx_data", rx_data, 0);
      end
      #1 rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("post-reset SS_n", SS_n, 1);
         chk("post-reset busy", busy, 0);
         chk("post-reset done", done, 0);
      end
      expect_req(11'h0A5, 13, 1, 15, 1'b0, 8'h00);
      issue(2'b00, 8'hA5);
      wait_idle();
      expect_req(11'h03C, 13, 1, 15, 1'b0, 8'h00);
      issue(2'b00, 8'h3C);
      repeat (3) @(negedge clk);
      start = 1'b1; cmd = 2'b01; data_in = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      expect_req(MWD, 13, 1, 15, 1'b0, 8'h00);
      issue(2'b01, RB);
      wait_idle();
`ifdef SPI_MASTER_AUTO_READ_EN
      expect_req(11'h700, 21, 2, 38, 1'b1, RB);
      issue(2'b10, 8'h3C);
      wait_idle();
`else
      expect_req(11'h63C, 13, 1, 15, 1'b0, 8'h00);
      issue(2'b10, 8'h3C);
      wait_idle();
      expect_req(11'h700, 21, 1, 23, 1'b1, RB);
      issue(2'b11, 8'hFF);
      wait_idle();
`endif
      issue(2'b01, 8'hC3);
      repeat (6) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mid-frame reset SS_n", SS_n, 1);
      chk("mid-frame reset busy", busy, 0);
      chk("mid-frame reset rx_data", rx_data, 0);
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("after reset done", done, 0);
`ifdef SPI_MASTER_AUTO_READ_EN
      expect_req(11'h700, 21, 2, 38, 1'b1, RB);
      issue(2'b10, 8'h3C);
`else
      expect_req(11'h700, 21, 1, 23, 1'b1, RB);
      issue(2'b11, 8'h00);
`endif
      wait_idle();
      repeat (5) @(negedge clk);
      chk("pending expectations", q.size() + bq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
